// File: rtl/spi_adc_sampler.sv
// SPI master for multi-channel serial ADCs: drives a channel address on MOSI and
// captures one DATA_W-bit sample per frame, tagged with the channel it came from.
module spi_adc_sampler #(
  parameter int DATA_W    = 12,
  parameter int LEAD_BITS = 4,
  parameter int CLK_DIV   = 1,
  parameter int CS_IDLE   = 2,
  parameter int CH_W      = 3,
  parameter int NUM_CH    = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              cont_en,
  input  logic              scan_en,
  input  logic [CH_W-1:0]   ch_sel,
  output logic              busy,
  output logic              CS,
  output logic              SCK,
  output logic              MOSI,
  input  logic              SDO,
  output logic [DATA_W-1:0] sample,
  output logic [CH_W-1:0]   sample_ch,
  output logic              sample_valid,
  output logic [1:0]        dbg_state
);

  localparam int FRAME_BITS = LEAD_BITS + DATA_W;
  localparam int BIT_W      = (FRAME_BITS > 1) ? $clog2(FRAME_BITS) : 1;
  localparam int CNT_MAX    = (CLK_DIV > CS_IDLE) ? CLK_DIV : CS_IDLE;
  localparam int CNT_W      = $clog2(CNT_MAX + 1);

  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(FRAME_BITS - 1);
  localparam logic [BIT_W-1:0] LEAD_L   = BIT_W'(LEAD_BITS);
  localparam logic [CH_W:0]    NUM_CH_L = (CH_W + 1)'(NUM_CH);
  localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(NUM_CH - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] SET_LOAD = CNT_W'(CLK_DIV);
  localparam logic [CNT_W-1:0] IDL_LOAD = CNT_W'(CS_IDLE - 1);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_SHIFT, S_HOLD} state_t;

  state_t             r_state, w_state_n;
  logic [CNT_W-1:0]   r_cnt, w_cnt_n;
  logic [BIT_W-1:0]   r_bit, w_bit_n;
  logic               r_sck, w_sck_n;
  logic               r_mosi, w_mosi_n;
  logic [DATA_W-1:0]  r_shift, w_shift_n;
  logic [CH_W-1:0]    r_addr_ch, w_addr_n;
  logic [CH_W-1:0]    r_conv_ch, w_conv_n;
  logic [DATA_W-1:0]  r_sample, w_sample_n;
  logic [CH_W-1:0]    r_sample_ch, w_sample_ch_n;
  logic               r_valid, w_valid_n;

  logic [DATA_W-1:0]  w_shift_in;
  logic [CH_W-1:0]    w_ch_sel_m;
  logic [CH_W-1:0]    w_ch_inc;
  logic [CH_W-1:0]    w_next_addr;

  // MOSI is zero except for the channel address, MSB first starting at frame bit 2.
  function automatic logic f_mosi(input logic [BIT_W-1:0] b, input logic [CH_W-1:0] a);
    logic r;
    r = 1'b0;
    for (int i = 0; i < CH_W; i++) begin
      if (int'(b) == 2 + CH_W - 1 - i) r = a[i];
    end
    return r;
  endfunction

  assign w_shift_in  = {r_shift[DATA_W-2:0], SDO};
  assign w_ch_sel_m  = ({1'b0, ch_sel} < NUM_CH_L) ? ch_sel : '0;
  assign w_ch_inc    = (r_addr_ch == CH_LAST) ? '0 : r_addr_ch + CH_W'(1);
  assign w_next_addr = scan_en ? w_ch_inc : w_ch_sel_m;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_bit       <= '0;
      r_sck       <= 1'b0;
      r_mosi      <= 1'b0;
      r_shift     <= '0;
      r_addr_ch   <= '0;
      r_conv_ch   <= '0;
      r_sample    <= '0;
      r_sample_ch <= '0;
      r_valid     <= 1'b0;
    end else begin
      r_state     <= w_state_n;
      r_cnt       <= w_cnt_n;
      r_bit       <= w_bit_n;
      r_sck       <= w_sck_n;
      r_mosi      <= w_mosi_n;
      r_shift     <= w_shift_n;
      r_addr_ch   <= w_addr_n;
      r_conv_ch   <= w_conv_n;
      r_sample    <= w_sample_n;
      r_sample_ch <= w_sample_ch_n;
      r_valid     <= w_valid_n;
    end
  end

  // The setup count includes the accept cycle, so CS leads the first SCK rise by CLK_DIV+1 clocks.
  always_comb begin
    w_state_n     = r_state;
    w_cnt_n       = r_cnt;
    w_bit_n       = r_bit;
    w_sck_n       = r_sck;
    w_mosi_n      = r_mosi;
    w_shift_n     = r_shift;
    w_addr_n      = r_addr_ch;
    w_conv_n      = r_conv_ch;
    w_sample_n    = r_sample;
    w_sample_ch_n = r_sample_ch;
    w_valid_n     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start || cont_en) begin
          w_state_n = S_SETUP;
          w_cnt_n   = SET_LOAD;
          w_bit_n   = '0;
          w_addr_n  = w_ch_sel_m;
          w_mosi_n  = f_mosi('0, w_ch_sel_m);
        end
      end
      S_SETUP: begin
        if (r_cnt == '0) begin
          w_state_n = S_SHIFT;
          w_sck_n   = 1'b1;
          w_cnt_n   = DIV_LOAD;
        end else begin
          w_cnt_n = r_cnt - CNT_W'(1);
        end
      end
      S_SHIFT: begin
        if (r_cnt != '0) begin
          w_cnt_n = r_cnt - CNT_W'(1);
        end else if (r_sck) begin
          // SCK falling edge: capture SDO and advance MOSI together.
          if (r_bit >= LEAD_L) w_shift_n = w_shift_in;
          if (r_bit == LAST_BIT) begin
            w_state_n     = S_HOLD;
            w_sck_n       = 1'b0;
            w_mosi_n      = 1'b0;
            w_sample_n    = w_shift_in;
            w_sample_ch_n = r_conv_ch;
            w_conv_n      = r_addr_ch;
            w_valid_n     = 1'b1;
            w_cnt_n       = IDL_LOAD;
          end else begin
            w_sck_n  = 1'b0;
            w_cnt_n  = DIV_LOAD;
            w_bit_n  = r_bit + BIT_W'(1);
            w_mosi_n = f_mosi(r_bit + BIT_W'(1), r_addr_ch);
          end
        end else begin
          w_sck_n = 1'b1;
          w_cnt_n = DIV_LOAD;
        end
      end
      S_HOLD: begin
        if (r_cnt != '0) begin
          w_cnt_n = r_cnt - CNT_W'(1);
        end else if (cont_en) begin
          w_state_n = S_SETUP;
          w_cnt_n   = SET_LOAD;
          w_bit_n   = '0;
          w_addr_n  = w_next_addr;
          w_mosi_n  = f_mosi('0, w_next_addr);
        end else begin
          w_state_n = S_IDLE;
        end
      end
      default: w_state_n = S_IDLE;
    endcase
  end

  assign busy         = (r_state != S_IDLE);
  assign CS           = !((r_state == S_SETUP) || (r_state == S_SHIFT));
  assign SCK          = r_sck;
  assign MOSI         = r_mosi;
  assign sample       = r_sample;
  assign sample_ch    = r_sample_ch;
  assign sample_valid = r_valid;
  assign dbg_state    = r_state;

endmodule
